lut_sweep_eval: RTL

LUT_SWEEP_EVAL -- requirements
Module: lut_sweep_eval

---
 rtl/lut_sweep_eval_if.sv | 37 +++
 rtl/lut_sweep_eval.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lut_sweep_eval_if.sv
// rtl/lut_sweep_eval_if.sv - control and result bundle for lut_sweep_eval (check signals under LUT_SWEEP_CHECK_EN)
interface lut_sweep_eval_if #(
   parameter int N = 4
);
   logic                 tt_load;
   logic                 tt_bit;
   logic                 start;
   logic [N-1:0]         code;
   logic                 v;
   logic                 valid;
   logic                 busy;
   logic                 done;
   logic [N:0]           ones_cnt;
`ifdef LUT_SWEEP_CHECK_EN
   logic [(1<<N)-1:0]    exp_tt;
   logic                 mismatch;
   logic [N-1:0]         fail_code;

   modport master (
      output tt_load, tt_bit, start, exp_tt,
      input  code, v, valid, busy, done, ones_cnt, mismatch, fail_code
   );
   modport slave (
      input  tt_load, tt_bit, start, exp_tt,
      output code, v, valid, busy, done, ones_cnt, mismatch, fail_code
   );
`else
   modport master (
      output tt_load, tt_bit, start,
      input  code, v, valid, busy, done, ones_cnt
   );
   modport slave (
      input  tt_load, tt_bit, start,
      output code, v, valid, busy, done, ones_cnt
   );
`endif
endinterface

// File: rtl/lut_sweep_eval.sv
// rtl/lut_sweep_eval.sv - serial-loaded truth table swept over all input codes (optional checker: LUT_SWEEP_CHECK_EN)
module lut_sweep_eval #(
   parameter int N     = 4,
   parameter int START = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   lut_sweep_eval_if.slave bus
);
   localparam int             TW         = 1 << N;
   localparam logic [N-1:0]   START_CODE = START[N-1:0];
   localparam logic [N:0]     SAMPLES    = TW[N:0];

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   tt;
   logic [N-1:0]    code_q;
   logic            v_q;
   logic            valid_q;
   logic            busy_q;
   logic            done_q;
   logic [N:0]      ones_q;
   logic [N:0]      sample_cnt;
   logic            accept;
   logic            last_sample;
   logic [N-1:0]    code_inc;

   // start is only honoured while idle; sample_cnt counts samples already presented
   assign accept      = (state == IDLE) && bus.start;
   assign last_sample = (sample_cnt == SAMPLES);
   assign code_inc    = code_q + N'(1);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: one sweep of 2^N samples, then a single DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_sample) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // truth-table shift register, MSB first, frozen outside IDLE and on a start cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tt <= '0;
      end else if ((state == IDLE) && bus.tt_load && !bus.start) begin
         tt <= {tt[TW-2:0], bus.tt_bit};
      end
   end

   // sweep datapath: registered code/v/valid, running count of ones lags one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code_q     <= '0;
         v_q        <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ones_q     <= '0;
         sample_cnt <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            code_q     <= START_CODE;
            v_q        <= tt[START_CODE];
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            ones_q     <= '0;
            sample_cnt <= (N+1)'(1);
         end else if (state == RUN) begin
            ones_q <= ones_q + {{N{1'b0}}, v_q};
            if (last_sample) begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               code_q     <= code_inc;
               v_q        <= tt[code_inc];
               sample_cnt <= sample_cnt + (N+1)'(1);
            end
         end
      end
   end

   assign bus.code     = code_q;
   assign bus.v        = v_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.ones_cnt = ones_q;

`ifdef LUT_SWEEP_CHECK_EN
   logic            mismatch_q;
   logic [N-1:0]    fail_code_q;

   // sticky compare against the expected table, remembering the first failing code
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mismatch_q  <= 1'b0;
         fail_code_q <= '0;
      end else if (accept) begin
         mismatch_q  <= 1'b0;
         fail_code_q <= '0;
      end else if (valid_q && !mismatch_q && (v_q != bus.exp_tt[code_q])) begin
         mismatch_q  <= 1'b1;
         fail_code_q <= code_q;
      end
   end

   assign bus.mismatch  = mismatch_q;
   assign bus.fail_code = fail_code_q;
`endif
endmodule
